// File: rtl/axi_stream_header_arbiter_if.sv
// Header-request, insert-port and output-monitor signals shared between the
// header arbiter (master) and the header sources / inserter (slave).
interface axi_stream_header_arbiter_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ*DATA_WD-1:0]      req_data;
    logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep;
    logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt;
    logic [NUM_REQ-1:0]              req_ready;

    logic                    valid_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    logic                    ready_insert;

    logic valid_out;
    logic ready_out;
    logic last_out;

    modport master (
        input  req_valid, req_data, req_keep, req_byte_cnt,
        output req_ready,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert,
        input  valid_out, ready_out, last_out
    );

    modport slave (
        output req_valid, req_data, req_keep, req_byte_cnt,
        input  req_ready,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert,
        output valid_out, ready_out, last_out
    );
endinterface

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter granting one header per packet to the AXI-Stream header inserter.
// Optional stall watchdog enabled by defining HDR_ARB_TIMEOUT_EN.
module axi_stream_header_arbiter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT      = 256,
    localparam int GRANT_WD    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    axi_stream_header_arbiter_if.master bus,
    output logic [GRANT_WD-1:0]         grant_id,
    output logic                        busy,
    output logic                        pkt_done,
    output logic                        timeout_err
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_OFFER    = 2'd1;
    localparam logic [1:0] ST_INFLIGHT = 2'd2;

    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("axi_stream_header_arbiter: NUM_REQ must be at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("axi_stream_header_arbiter: TIMEOUT must be at least 2");
    end

    logic [1:0]              state_q, state_d;
    logic [GRANT_WD-1:0]     ptr_q;
    logic [GRANT_WD-1:0]     grant_q;
    logic [DATA_WD-1:0]      data_q;
    logic [DATA_BYTE_WD-1:0] keep_q;
    logic [BYTE_CNT_WD-1:0]  cnt_q;
    logic                    pkt_done_q;

    logic                    grant_en;
    logic [GRANT_WD-1:0]     sel;
    logic                    hdr_fire;
    logic                    last_fire;
    logic                    stall_hit;

    // First asserted requester strictly after ptr, wrapping around.
    function automatic logic [GRANT_WD-1:0] rr_pick(input logic [NUM_REQ-1:0]  valid,
                                                    input logic [GRANT_WD-1:0] ptr);
        logic [GRANT_WD-1:0] pick;
        logic                found;
        int                  idx;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[idx]) begin
                pick  = GRANT_WD'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign sel = rr_pick(bus.req_valid, ptr_q);

    // The cycle carrying pkt_done is kept grant-free so grants are always spaced.
    assign grant_en  = (state_q == ST_IDLE) && (|bus.req_valid) && !pkt_done_q;
    assign hdr_fire  = (state_q == ST_OFFER) && bus.ready_insert;
    assign last_fire = (state_q == ST_INFLIGHT) && bus.valid_out && bus.ready_out
                       && bus.last_out;

`ifdef HDR_ARB_TIMEOUT_EN
    localparam int STALL_WD = $clog2(TIMEOUT);

    logic [STALL_WD-1:0] stall_q;
    logic                stall_clr;
    logic                timeout_err_q;

    assign stall_clr = hdr_fire || (bus.valid_out && bus.ready_out);
    assign stall_hit = busy && !stall_clr && (stall_q == STALL_WD'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (!busy || stall_clr || stall_hit) begin
                stall_q <= '0;
            end else begin
                stall_q <= stall_q + 1'b1;
            end
            if (stall_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign stall_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (grant_en)  state_d = ST_OFFER;
            ST_OFFER:    if (hdr_fire)  state_d = ST_INFLIGHT;
            ST_INFLIGHT: if (last_fire) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
        if (stall_hit) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= GRANT_WD'(NUM_REQ - 1);
            grant_q    <= '0;
            data_q     <= '0;
            keep_q     <= '0;
            cnt_q      <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_done_q <= last_fire;
            if (grant_en) begin
                grant_q <= sel;
                data_q  <= bus.req_data[int'(sel)*DATA_WD +: DATA_WD];
                keep_q  <= bus.req_keep[int'(sel)*DATA_BYTE_WD +: DATA_BYTE_WD];
                cnt_q   <= bus.req_byte_cnt[int'(sel)*BYTE_CNT_WD +: BYTE_CNT_WD];
            end
            if (last_fire || stall_hit) begin
                ptr_q <= grant_q;
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (grant_en) begin
            bus.req_ready[sel] = 1'b1;
        end
    end

    assign bus.valid_insert    = (state_q == ST_OFFER);
    assign bus.data_insert     = data_q;
    assign bus.keep_insert     = keep_q;
    assign bus.byte_insert_cnt = cnt_q;

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign pkt_done = pkt_done_q;

    a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    a_req_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != ST_IDLE) |-> (bus.req_ready == '0));

    a_offer_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_OFFER && !bus.ready_insert) |=> $stable(data_q) && $stable(keep_q)
        && $stable(cnt_q));

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Directed self-checking bench for axi_stream_header_arbiter (4 sources, 32-bit headers).
module tb_axi_stream_header_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] grant_id;
    logic       busy;
    logic       pkt_done;
    logic       timeout_err;

    int total;
    int bad;

    axi_stream_header_arbiter_if #(.DATA_WD(32), .NUM_REQ(4)) bus ();

    axi_stream_header_arbiter #(
        .DATA_WD (32),
        .NUM_REQ (4),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .pkt_done    (pkt_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_packet();
        bus.ready_insert = 1'b1;
        tick();
        bus.ready_insert = 1'b0;
        bus.valid_out = 1'b1;
        bus.ready_out = 1'b1;
        bus.last_out  = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        bus.ready_out = 1'b0;
        bus.last_out  = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.req_ready !== 4'b0000 || bus.valid_insert !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake got ready=%b vins=%b exp 0000/0", bus.req_ready,
                     bus.valid_insert);
        end
        total++;
        if (bus.data_insert !== 32'h0 || bus.keep_insert !== 4'h0 ||
            bus.byte_insert_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_payload got %h/%b/%0d exp 0", bus.data_insert,
                     bus.keep_insert, bus.byte_insert_cnt);
        end
        total++;
        if (grant_id !== 2'd0 || busy !== 1'b0 || pkt_done !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_status got gid=%0d busy=%b done=%b terr=%b exp 0",
                     grant_id, busy, pkt_done, timeout_err);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_round_robin();
        int         waited;
        logic [1:0] exp_id;
        for (int i = 0; i < 4; i++) begin
            bus.req_data[i*32 +: 32]    = 32'hC0DE_0000 + i;
            bus.req_keep[i*4 +: 4]      = 4'hF;
            bus.req_byte_cnt[i*2 +: 2]  = 2'(i);
        end
        bus.req_valid = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            waited = 0;
            while (bus.req_ready == 4'b0000 && waited < 8) begin
                tick();
                waited++;
            end
            total++;
            if (bus.req_ready !== (4'b0001 << exp_id)) begin
                bad++;
                $display("FAIL rr_ready pkt%0d got=%b exp=%b", k, bus.req_ready,
                         4'b0001 << exp_id);
            end
            if (k > 0) begin
                total++;
                if (waited != 0) begin
                    bad++;
                    $display("FAIL rr_gap pkt%0d got wait=%0d exp 0", k, waited);
                end
            end
            tick();
            total++;
            if (grant_id !== exp_id || bus.data_insert !== (32'hC0DE_0000 + k % 4)) begin
                bad++;
                $display("FAIL rr_grant pkt%0d got gid=%0d data=%h exp gid=%0d data=%h", k,
                         grant_id, bus.data_insert, exp_id, 32'hC0DE_0000 + k % 4);
            end
            bus.ready_insert = 1'b1;
            tick();
            bus.ready_insert = 1'b0;
            bus.valid_out = 1'b1;
            bus.ready_out = 1'b1;
            bus.last_out  = 1'b1;
            tick();
            bus.valid_out = 1'b0;
            bus.ready_out = 1'b0;
            bus.last_out  = 1'b0;
            total++;
            if (pkt_done !== 1'b1 || bus.req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL rr_done pkt%0d got done=%b ready=%b exp 1/0000", k, pkt_done,
                         bus.req_ready);
            end
            tick();
        end
        bus.req_valid = 4'h0;
        tick();
    endtask

    task automatic test_single();
        bus.req_data[2*32 +: 32]   = 32'hAA55AA55;
        bus.req_keep[2*4 +: 4]     = 4'b0111;
        bus.req_byte_cnt[2*2 +: 2] = 2'd3;
        bus.req_valid = 4'b0100;
        #1;
        total++;
        if (bus.req_ready !== 4'b0100 || bus.valid_insert !== 1'b0) begin
            bad++;
            $display("FAIL single_ready got=%b vins=%b exp 0100/0", bus.req_ready,
                     bus.valid_insert);
        end
        tick();
        bus.req_valid = 4'b0000;
        total++;
        if (bus.valid_insert !== 1'b1 || bus.data_insert !== 32'hAA55AA55 ||
            bus.keep_insert !== 4'b0111 || bus.byte_insert_cnt !== 2'd3) begin
            bad++;
            $display("FAIL single_offer got v=%b %h/%b/%0d exp 1 aa55aa55/0111/3",
                     bus.valid_insert, bus.data_insert, bus.keep_insert, bus.byte_insert_cnt);
        end
        total++;
        if (grant_id !== 2'd2 || busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL single_grant got gid=%0d busy=%b ready=%b exp 2/1/0000", grant_id,
                     busy, bus.req_ready);
        end
        bus.ready_insert = 1'b1;
        tick();
        bus.ready_insert = 1'b0;
        total++;
        if (bus.valid_insert !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_inflight got vins=%b busy=%b exp 0/1", bus.valid_insert, busy);
        end
        bus.valid_out = 1'b1;
        bus.ready_out = 1'b1;
        tick();
        total++;
        if (pkt_done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_midbeat got done=%b busy=%b exp 0/1", pkt_done, busy);
        end
        bus.last_out = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        bus.ready_out = 1'b0;
        bus.last_out  = 1'b0;
        total++;
        if (pkt_done !== 1'b1 || busy !== 1'b0 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL single_done got done=%b busy=%b gid=%0d exp 1/0/2", pkt_done, busy,
                     grant_id);
        end
        tick();
        total++;
        if (pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse got done=%b exp 0", pkt_done);
        end
    endtask

    task automatic test_backpressure();
        bus.req_data[2*32 +: 32] = 32'hAA55AA55;
        bus.req_keep[2*4 +: 4]   = 4'b0111;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_data[2*32 +: 32] = 32'hAA55AA66;
        bus.req_keep[2*4 +: 4]   = 4'b1111;
        // Output beats seen while still offering must not complete the packet.
        bus.valid_out = 1'b1;
        bus.ready_out = 1'b1;
        bus.last_out  = 1'b1;
        for (int c = 0; c < 6; c++) begin
            total++;
            if (bus.valid_insert !== 1'b1 || bus.data_insert !== 32'hAA55AA55 ||
                bus.keep_insert !== 4'b0111 || bus.req_ready !== 4'b0000 ||
                pkt_done !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold c%0d got v=%b d=%h k=%b rdy=%b done=%b exp 1 aa55aa55 0111 0000 0",
                         c, bus.valid_insert, bus.data_insert, bus.keep_insert, bus.req_ready,
                         pkt_done);
            end
            tick();
        end
        bus.valid_out = 1'b0;
        bus.ready_out = 1'b0;
        bus.last_out  = 1'b0;
        bus.req_valid = 4'b0000;
        finish_packet();
        total++;
        if (busy !== 1'b0 || grant_id !== 2'd2) begin
            bad++;
            $display("FAIL bp_end got busy=%b gid=%0d exp 0/2", busy, grant_id);
        end
        tick();
    endtask

    task automatic test_output_stall();
        bus.req_data[3*32 +: 32] = 32'h3333_0003;
        bus.req_valid = 4'b1000;
        tick();
        bus.req_valid = 4'b0000;
        bus.ready_insert = 1'b1;
        tick();
        bus.ready_insert = 1'b0;
        bus.valid_out = 1'b1;
        bus.last_out  = 1'b1;
        bus.ready_out = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (pkt_done !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL stall_wait c%0d got done=%b busy=%b exp 0/1", c, pkt_done, busy);
            end
        end
        bus.ready_out = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        bus.ready_out = 1'b0;
        bus.last_out  = 1'b0;
        total++;
        if (pkt_done !== 1'b1 || grant_id !== 2'd3) begin
            bad++;
            $display("FAIL stall_done got done=%b gid=%0d exp 1/3", pkt_done, grant_id);
        end
        tick();
    endtask

    task automatic test_reset_inflight();
        bus.req_data[1*32 +: 32] = 32'h1111_0001;
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        total++;
        if (grant_id !== 2'd1 || bus.valid_insert !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre got gid=%0d vins=%b exp 1/1", grant_id, bus.valid_insert);
        end
        bus.ready_insert = 1'b1;
        tick();
        bus.ready_insert = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || grant_id !== 2'd0 || bus.data_insert !== 32'h0 ||
            bus.valid_insert !== 1'b0 || bus.req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_async got busy=%b gid=%0d d=%h v=%b rdy=%b exp all 0", busy,
                     grant_id, bus.data_insert, bus.valid_insert, bus.req_ready);
        end
        bus.req_data[0*32 +: 32] = 32'h0000_00A0;
        bus.req_data[3*32 +: 32] = 32'h0000_00A3;
        bus.req_valid = 4'b1001;
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rst_rr_ready got=%b exp=0001", bus.req_ready);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 4'b0000;
        total++;
        if (grant_id !== 2'd0 || bus.data_insert !== 32'h0000_00A0) begin
            bad++;
            $display("FAIL rst_rr_grant got gid=%0d d=%h exp 0/000000a0", grant_id,
                     bus.data_insert);
        end
        finish_packet();
    endtask

`ifdef HDR_ARB_TIMEOUT_EN
    task automatic test_timeout();
        bus.req_data[2*32 +: 32] = 32'h2222_0002;
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        bus.ready_insert = 1'b1;
        tick();
        bus.ready_insert = 1'b0;
        repeat (15) tick();
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL tmo_early got terr=%b busy=%b exp 0/1", timeout_err, busy);
        end
        tick();
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || bus.valid_insert !== 1'b0 ||
            pkt_done !== 1'b0) begin
            bad++;
            $display("FAIL tmo_fire got terr=%b busy=%b v=%b done=%b exp 1/0/0/0", timeout_err,
                     busy, bus.valid_insert, pkt_done);
        end
        bus.req_data[0*32 +: 32] = 32'h0BAD_0000;
        bus.req_valid = 4'b0001;
        #1;
        total++;
        if (bus.req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL tmo_regrant got=%b exp=0001", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0000;
        total++;
        if (bus.valid_insert !== 1'b1 || bus.data_insert !== 32'h0BAD_0000) begin
            bad++;
            $display("FAIL tmo_offer got v=%b d=%h exp 1/0bad0000", bus.valid_insert,
                     bus.data_insert);
        end
        finish_packet();
        total++;
        if (timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky got terr=%b exp 1", timeout_err);
        end
    endtask
`else
    task automatic test_no_timeout();
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        bus.ready_insert = 1'b1;
        tick();
        bus.ready_insert = 1'b0;
        repeat (20) tick();
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL no_tmo got terr=%b busy=%b exp 0/1", timeout_err, busy);
        end
        bus.valid_out = 1'b1;
        bus.ready_out = 1'b1;
        bus.last_out  = 1'b1;
        tick();
        bus.valid_out = 1'b0;
        bus.ready_out = 1'b0;
        bus.last_out  = 1'b0;
        total++;
        if (pkt_done !== 1'b1) begin
            bad++;
            $display("FAIL no_tmo_done got done=%b exp 1", pkt_done);
        end
        tick();
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.req_valid    = '0;
        bus.req_data     = '0;
        bus.req_keep     = '0;
        bus.req_byte_cnt = '0;
        bus.ready_insert = 1'b0;
        bus.valid_out    = 1'b0;
        bus.ready_out    = 1'b0;
        bus.last_out     = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_output_stall();
        test_reset_inflight();
`ifdef HDR_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
